// File: rtl/controller_fsm_rx_if.sv
// ---------------------------------------------------------------------------
// controller_fsm_rx_if
// Purpose : groups the UART receive byte stream and the decoded register-file
//           / ALU command outputs of the receive-side controller.
// Signals :
//   RX_P_Data   - received byte, valid while RX_D_VLD=1
//   RX_D_VLD    - one-cycle pulse per received byte
//   WrEn/RdEn   - register-file write / read strobes
//   Address     - register-file address (held between strobes)
//   WrData      - register-file write data (held between strobes)
//   ALU_EN      - ALU execute strobe
//   ALU_FUN     - ALU function code (held between strobes)
//   CLK_GATE_EN - ALU clock-gate enable
//   FRAME_ABORT - pulse when a partial frame is discarded
// Modports: master = byte source / command consumer side, slave = controller.
// ---------------------------------------------------------------------------
interface controller_fsm_rx_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned FUN_WIDTH  = 4
);
    logic [DATA_WIDTH-1:0] RX_P_Data;
    logic                  RX_D_VLD;
    logic                  WrEn;
    logic                  RdEn;
    logic [ADDR_WIDTH-1:0] Address;
    logic [DATA_WIDTH-1:0] WrData;
    logic                  ALU_EN;
    logic [FUN_WIDTH-1:0]  ALU_FUN;
    logic                  CLK_GATE_EN;
    logic                  FRAME_ABORT;

    modport master (
        output RX_P_Data, RX_D_VLD,
        input  WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_GATE_EN, FRAME_ABORT
    );

    modport slave (
        input  RX_P_Data, RX_D_VLD,
        output WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_GATE_EN, FRAME_ABORT
    );
endinterface

// File: rtl/controller_fsm_rx.sv
// ---------------------------------------------------------------------------
// controller_fsm_rx
// Purpose : receive-side system controller. Decodes UART command frames into
//           register-file write/read strobes and ALU execute strobes.
//           Frames: AA addr data | BB addr | CC opA opB fun | DD fun.
// Ports   :
//   CLK  - system clock
//   RST  - synchronous active-high reset
//   bus  - controller_fsm_rx_if.slave (received bytes in, decoded commands out)
// Options :
//   CTRL_RX_TIMEOUT_EN - when defined, a partial frame idle for
//                        TIMEOUT_CYCLES cycles is discarded and FRAME_ABORT
//                        pulses; otherwise FRAME_ABORT is tied low.
// All outputs are registered.
// ---------------------------------------------------------------------------
module controller_fsm_rx #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned FUN_WIDTH      = 4,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic                   CLK,
    input  logic                   RST,
    controller_fsm_rx_if.slave     bus
);

    localparam logic [DATA_WIDTH-1:0] CMD_WR      = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD      = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP  = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_NOP = DATA_WIDTH'(8'hDD);

    // Fixed register-file slots for ALU operands
    localparam logic [ADDR_WIDTH-1:0] OPA_ADDR = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] OPB_ADDR = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_ADDR  = 3'd1,
        WR_DATA  = 3'd2,
        RD_ADDR  = 3'd3,
        ALU_OPA  = 3'd4,
        ALU_OPB  = 3'd5,
        ALU_FUNC = 3'd6
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr_lat;
    logic                  r_wr_en;
    logic                  r_rd_en;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic                  r_alu_en;
    logic [FUN_WIDTH-1:0]  r_alu_fun;
    logic                  r_gate_en;
    logic                  r_abort;

    logic [DATA_WIDTH-1:0] w_byte;
    logic                  w_vld;

    assign w_byte = bus.RX_P_Data;
    assign w_vld  = bus.RX_D_VLD;

`ifdef CTRL_RX_TIMEOUT_EN
    logic [15:0] r_idle_cnt;
`else
    logic [15:0] w_unused_timeout;
    assign w_unused_timeout = TIMEOUT_CYCLES;
`endif

    // Frame decoder: state, latched fields and registered strobes
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= IDLE;
            r_addr_lat <= '0;
            r_wr_en    <= 1'b0;
            r_rd_en    <= 1'b0;
            r_addr     <= '0;
            r_wr_data  <= '0;
            r_alu_en   <= 1'b0;
            r_alu_fun  <= '0;
            r_gate_en  <= 1'b0;
            r_abort    <= 1'b0;
`ifdef CTRL_RX_TIMEOUT_EN
            r_idle_cnt <= 16'd0;
`endif
        end else begin
            r_wr_en  <= 1'b0;
            r_rd_en  <= 1'b0;
            r_alu_en <= 1'b0;
            r_abort  <= 1'b0;

            // Gate falls one cycle after ALU_EN unless a new ALU frame starts now
            if (r_alu_en) begin
                r_gate_en <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_vld) begin
                        if (w_byte == CMD_WR) begin
                            r_state <= WR_ADDR;
                        end else if (w_byte == CMD_RD) begin
                            r_state <= RD_ADDR;
                        end else if (w_byte == CMD_ALU_OP) begin
                            r_state   <= ALU_OPA;
                            r_gate_en <= 1'b1;
                        end else if (w_byte == CMD_ALU_NOP) begin
                            r_state   <= ALU_FUNC;
                            r_gate_en <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end

                WR_ADDR: begin
                    if (w_vld) begin
                        r_addr_lat <= w_byte[ADDR_WIDTH-1:0];
                        r_state    <= WR_DATA;
                    end
                end

                WR_DATA: begin
                    if (w_vld) begin
                        r_wr_en   <= 1'b1;
                        r_addr    <= r_addr_lat;
                        r_wr_data <= w_byte;
                        r_state   <= IDLE;
                    end
                end

                RD_ADDR: begin
                    if (w_vld) begin
                        r_rd_en <= 1'b1;
                        r_addr  <= w_byte[ADDR_WIDTH-1:0];
                        r_state <= IDLE;
                    end
                end

                ALU_OPA: begin
                    if (w_vld) begin
                        r_wr_en   <= 1'b1;
                        r_addr    <= OPA_ADDR;
                        r_wr_data <= w_byte;
                        r_state   <= ALU_OPB;
                    end
                end

                ALU_OPB: begin
                    if (w_vld) begin
                        r_wr_en   <= 1'b1;
                        r_addr    <= OPB_ADDR;
                        r_wr_data <= w_byte;
                        r_state   <= ALU_FUNC;
                    end
                end

                ALU_FUNC: begin
                    if (w_vld) begin
                        r_alu_en  <= 1'b1;
                        r_alu_fun <= w_byte[FUN_WIDTH-1:0];
                        r_state   <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase

`ifdef CTRL_RX_TIMEOUT_EN
            // Idle watchdog inside a partial frame; overrides the decoder on expiry
            if (r_state == IDLE || w_vld) begin
                r_idle_cnt <= 16'd0;
            end else if (r_idle_cnt == (TIMEOUT_CYCLES - 16'd1)) begin
                r_idle_cnt <= 16'd0;
                r_state    <= IDLE;
                r_abort    <= 1'b1;
                r_gate_en  <= 1'b0;
            end else begin
                r_idle_cnt <= r_idle_cnt + 16'd1;
            end
`endif
        end
    end

    assign bus.WrEn        = r_wr_en;
    assign bus.RdEn        = r_rd_en;
    assign bus.Address     = r_addr;
    assign bus.WrData      = r_wr_data;
    assign bus.ALU_EN      = r_alu_en;
    assign bus.ALU_FUN     = r_alu_fun;
    assign bus.CLK_GATE_EN = r_gate_en;
    assign bus.FRAME_ABORT = r_abort;

endmodule

// File: tb/tb_controller_fsm_rx.sv
// ---------------------------------------------------------------------------
// tb_controller_fsm_rx
// Purpose : self-checking bench for controller_fsm_rx. A frame-level model
//           (command byte + byte count of the frame in progress) predicts
//           every output each cycle; directed sequences pin the model with
//           literal expectations, then randomized frames, junk bytes, gaps
//           and mid-frame resets exercise the decoder.
// ---------------------------------------------------------------------------
module tb_controller_fsm_rx;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;
    localparam int unsigned FW = 4;
`ifdef CTRL_RX_TIMEOUT_EN
    localparam logic [15:0] TO = 16'd20;
`else
    localparam logic [15:0] TO = 16'd50000;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    controller_fsm_rx_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FUN_WIDTH(FW)) bus ();

    controller_fsm_rx #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .FUN_WIDTH     (FW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus.slave)
    );

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    int         m_len  = 0;   // bytes of the current frame received so far
    int         m_idle = 0;   // idle cycles inside the current partial frame
    logic [7:0] m_cmd  = 8'h00;
    logic [7:0] m_b1   = 8'h00;
    logic       e_wr = 0, e_rd = 0, e_alu = 0, e_gate = 0, e_abort = 0;
    logic [3:0] e_addr = 0, e_fun = 0;
    logic [7:0] e_data = 0;

    always @(posedge CLK) begin : model
        logic       prev_alu;
        logic [7:0] b;
        if (RST) begin
            m_len = 0; m_idle = 0;
            e_wr = 0; e_rd = 0; e_alu = 0; e_gate = 0; e_abort = 0;
            e_addr = 0; e_data = 0; e_fun = 0;
        end else begin
            prev_alu = e_alu;
            e_wr = 0; e_rd = 0; e_alu = 0; e_abort = 0;
            if (prev_alu) e_gate = 0;
            if (bus.RX_D_VLD) begin
                b = bus.RX_P_Data;
                m_idle = 0;
                if (m_len == 0) begin
                    if (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD) begin
                        m_cmd = b;
                        m_len = 1;
                        if (b == 8'hCC || b == 8'hDD) e_gate = 1;
                    end
                end else begin
                    m_len++;
                    case (m_cmd)
                        8'hAA: if (m_len == 2) m_b1 = b;
                               else begin e_wr = 1; e_addr = m_b1[3:0]; e_data = b; m_len = 0; end
                        8'hBB: begin e_rd = 1; e_addr = b[3:0]; m_len = 0; end
                        8'hCC: if (m_len == 2) begin e_wr = 1; e_addr = 4'd0; e_data = b; end
                               else if (m_len == 3) begin e_wr = 1; e_addr = 4'd1; e_data = b; end
                               else begin e_alu = 1; e_fun = b[3:0]; m_len = 0; end
                        default: begin e_alu = 1; e_fun = b[3:0]; m_len = 0; end
                    endcase
                end
            end else if (m_len != 0) begin
`ifdef CTRL_RX_TIMEOUT_EN
                m_idle++;
                if (m_idle == int'(TO)) begin
                    e_abort = 1; e_gate = 0; m_len = 0; m_idle = 0;
                end
`endif
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("wr_en",   32'(bus.WrEn),        32'(e_wr));
            chk("rd_en",   32'(bus.RdEn),        32'(e_rd));
            chk("alu_en",  32'(bus.ALU_EN),      32'(e_alu));
            chk("gate",    32'(bus.CLK_GATE_EN), 32'(e_gate));
            chk("abort",   32'(bus.FRAME_ABORT), 32'(e_abort));
            chk("address", 32'(bus.Address),     32'(e_addr));
            chk("wr_data", 32'(bus.WrData),      32'(e_data));
            chk("alu_fun", 32'(bus.ALU_FUN),     32'(e_fun));
        end
    end

    // One stimulus cycle: inputs change on the falling edge
    task automatic cyc(input logic r, input logic v, input logic [7:0] d);
        @(negedge CLK);
        RST = r;
        bus.RX_D_VLD  = v;
        bus.RX_P_Data = d;
    endtask

    task automatic chk_strobes(input string nm, input logic wr, input logic rd, input logic alu);
        chk({nm, "_wr"},  32'(bus.WrEn),   32'(wr));
        chk({nm, "_rd"},  32'(bus.RdEn),   32'(rd));
        chk({nm, "_alu"}, 32'(bus.ALU_EN), 32'(alu));
    endtask

    initial begin
        logic [7:0] q[$];
        int         kind;
        bus.RX_D_VLD  = 1'b0;
        bus.RX_P_Data = 8'h00;

        // reset
        cyc(1, 0, 8'h00);
        cyc(1, 0, 8'h00);
        cyc(0, 0, 8'h00);
        chk_en = 1'b1;
        chk_strobes("lit_reset", 0, 0, 0);
        chk("lit_reset_addr",  32'(bus.Address),     32'h0);
        chk("lit_reset_data",  32'(bus.WrData),      32'h0);
        chk("lit_reset_fun",   32'(bus.ALU_FUN),     32'h0);
        chk("lit_reset_gate",  32'(bus.CLK_GATE_EN), 32'h0);
        chk("lit_reset_abort", 32'(bus.FRAME_ABORT), 32'h0);

        // register write with address truncation
        cyc(0, 1, 8'hAA);
        cyc(0, 1, 8'h15);
        cyc(0, 1, 8'h3C);
        chk_strobes("lit_wr_mid", 0, 0, 0);
        cyc(0, 0, 8'h00);
        chk_strobes("lit_wr", 1, 0, 0);
        chk("lit_wr_addr", 32'(bus.Address), 32'h5);
        chk("lit_wr_data", 32'(bus.WrData),  32'h3C);
        cyc(0, 0, 8'h00);
        chk_strobes("lit_wr_after", 0, 0, 0);
        chk("lit_wr_hold", 32'(bus.WrData), 32'h3C);

        // register read
        cyc(0, 1, 8'hBB);
        cyc(0, 1, 8'h07);
        cyc(0, 0, 8'h00);
        chk_strobes("lit_rd", 0, 1, 0);
        chk("lit_rd_addr", 32'(bus.Address), 32'h7);

        // ALU with operands
        cyc(0, 1, 8'hCC);
        cyc(0, 1, 8'h12);
        chk("lit_alu_gate_rise", 32'(bus.CLK_GATE_EN), 32'h1);
        chk_strobes("lit_alu_cmd", 0, 0, 0);
        cyc(0, 1, 8'h34);
        chk_strobes("lit_alu_opa", 1, 0, 0);
        chk("lit_alu_opa_addr", 32'(bus.Address), 32'h0);
        chk("lit_alu_opa_data", 32'(bus.WrData),  32'h12);
        cyc(0, 1, 8'h02);
        chk_strobes("lit_alu_opb", 1, 0, 0);
        chk("lit_alu_opb_addr", 32'(bus.Address), 32'h1);
        chk("lit_alu_opb_data", 32'(bus.WrData),  32'h34);
        cyc(0, 0, 8'h00);
        chk_strobes("lit_alu_ex", 0, 0, 1);
        chk("lit_alu_fun",  32'(bus.ALU_FUN),     32'h2);
        chk("lit_alu_gate", 32'(bus.CLK_GATE_EN), 32'h1);
        cyc(0, 0, 8'h00);
        chk("lit_alu_gate_fall", 32'(bus.CLK_GATE_EN), 32'h0);

        // junk byte then back-to-back no-operand ALU frame
        cyc(0, 1, 8'h55);
        cyc(0, 1, 8'hDD);
        chk_strobes("lit_junk", 0, 0, 0);
        chk("lit_junk_gate", 32'(bus.CLK_GATE_EN), 32'h0);
        cyc(0, 1, 8'h09);
        chk("lit_dd_gate", 32'(bus.CLK_GATE_EN), 32'h1);
        cyc(0, 0, 8'h00);
        chk_strobes("lit_dd", 0, 0, 1);
        chk("lit_dd_fun", 32'(bus.ALU_FUN), 32'h9);

        // reset mid-frame (byte on the reset cycle is dropped), then a read
        cyc(0, 1, 8'hAA);
        cyc(1, 1, 8'h22);
        cyc(0, 1, 8'h33);
        chk_strobes("lit_rst_mid", 0, 0, 0);
        chk("lit_rst_mid_addr", 32'(bus.Address), 32'h0);
        chk("lit_rst_mid_data", 32'(bus.WrData),  32'h0);
        chk("lit_rst_mid_fun",  32'(bus.ALU_FUN), 32'h0);
        cyc(0, 1, 8'hBB);
        chk_strobes("lit_rst_junk", 0, 0, 0);
        cyc(0, 1, 8'h07);
        cyc(0, 0, 8'h00);
        chk_strobes("lit_rst_rd", 0, 1, 0);
        chk("lit_rst_rd_addr", 32'(bus.Address), 32'h7);

`ifdef CTRL_RX_TIMEOUT_EN
        // partial frame timeout after TO idle cycles
        cyc(0, 1, 8'hCC);
        for (int i = 0; i < 20; i++) cyc(0, 0, 8'h00);
        chk("lit_to_before", 32'(bus.FRAME_ABORT), 32'h0);
        chk("lit_to_gate_hi", 32'(bus.CLK_GATE_EN), 32'h1);
        cyc(0, 0, 8'h00);
        chk("lit_to_abort", 32'(bus.FRAME_ABORT), 32'h1);
        chk("lit_to_gate_lo", 32'(bus.CLK_GATE_EN), 32'h0);
        chk_strobes("lit_to", 0, 0, 0);
        cyc(0, 0, 8'h00);
        chk("lit_to_pulse", 32'(bus.FRAME_ABORT), 32'h0);
`else
        // partial frame waits indefinitely
        cyc(0, 1, 8'hCC);
        for (int i = 0; i < 30; i++) cyc(0, 0, 8'h00);
        chk("lit_wait_abort", 32'(bus.FRAME_ABORT), 32'h0);
        chk("lit_wait_gate",  32'(bus.CLK_GATE_EN), 32'h1);
        cyc(0, 1, 8'hA1);
        cyc(0, 0, 8'h00);
        chk_strobes("lit_wait_opa", 1, 0, 0);
        chk("lit_wait_opa_data", 32'(bus.WrData), 32'hA1);
        cyc(0, 1, 8'hB2);
        cyc(0, 1, 8'hF3);
        cyc(0, 0, 8'h00);
        chk_strobes("lit_wait_ex", 0, 0, 1);
        chk("lit_wait_fun", 32'(bus.ALU_FUN), 32'h3);
`endif

        // randomized frames, junk, gaps and occasional mid-frame resets
        for (int f = 0; f < 400; f++) begin
            q.delete();
            kind = int'($urandom_range(0, 4));
            case (kind)
                0: begin q.push_back(8'hAA); q.push_back(8'($urandom)); q.push_back(8'($urandom)); end
                1: begin q.push_back(8'hBB); q.push_back(8'($urandom)); end
                2: begin q.push_back(8'hCC); q.push_back(8'($urandom));
                         q.push_back(8'($urandom)); q.push_back(8'($urandom)); end
                3: begin q.push_back(8'hDD); q.push_back(8'($urandom)); end
                default: q.push_back(8'($urandom));
            endcase
            foreach (q[k]) begin
                if ($urandom_range(0, 39) == 0)
                    cyc(1, 1'($urandom_range(0, 1)), 8'($urandom));
                cyc(0, 1, q[k]);
                for (int g = int'($urandom_range(0, 2)); g > 0; g--)
                    if ($urandom_range(0, 1) == 0) cyc(0, 0, 8'($urandom));
            end
            for (int g = int'($urandom_range(0, 3)); g > 0; g--) cyc(0, 0, 8'($urandom));
        end

        cyc(0, 0, 8'h00);
        cyc(0, 0, 8'h00);
        cyc(0, 0, 8'h00);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/controller_fsm_rx.md
# controller_fsm_rx

Receive-side system controller for the UART control system. Consumes the parallel bytes delivered by the UART receiver and decodes command frames into register-file write/read strobes and ALU execute strobes. Its read and ALU results return to the host through the transmit-side controller. All outputs are registered.

## Interface
- DATA_WIDTH, 8, UART byte width and register-file data width.
- ADDR_WIDTH, 4, register-file address width; taken from the low bits of the address byte.
- FUN_WIDTH, 4, ALU function code width; taken from the low bits of the function byte.
- TIMEOUT_CYCLES, 16'd50000, number of idle cycles allowed inside a partial frame (used only with `CTRL_RX_TIMEOUT_EN`).
- CLK  in  1  system clock; the block uses one clock only.
- RST  in  1  synchronous, active-high reset.
- RX_P_Data  in  DATA_WIDTH  received byte; valid only while RX_D_VLD=1.
- RX_D_VLD  in  1  one-cycle pulse per received byte.
- WrEn  out  1  register-file write strobe, one cycle.
- RdEn  out  1  register-file read strobe, one cycle.
- Address  out  ADDR_WIDTH  register-file address; holds its value between strobes.
- WrData  out  DATA_WIDTH  register-file write data; holds its value between strobes.
- ALU_EN  out  1  ALU execute strobe, one cycle.
- ALU_FUN  out  FUN_WIDTH  ALU function code; holds its value between strobes.
- CLK_GATE_EN  out  1  ALU clock-gate enable.
- FRAME_ABORT  out  1  one-cycle pulse when a partial frame is discarded.

## Operation
- Frame formats, with the first byte as the command:
  - 0xAA, addr, data: register write.
  - 0xBB, addr: register read.
  - 0xCC, opA, opB, fun: ALU operation with operands.
  - 0xDD, fun: ALU operation without operands.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_OPA, ALU_OPB, ALU_FUNC.
- Every transition requires RX_D_VLD=1. No byte is consumed when RX_D_VLD=0.
- Transitions and actions:
  - IDLE:
    - 0xAA goes to WR_ADDR.
    - 0xBB goes to RD_ADDR.
    - 0xCC goes to ALU_OPA.
    - 0xDD goes to ALU_FUNC.
    - Any other byte is dropped and the state stays IDLE. No output changes.
  - WR_ADDR: latch the address byte, then go to WR_DATA.
  - WR_DATA: issue a WrEn pulse with the latched Address and WrData equal to the byte, then go to IDLE.
  - RD_ADDR: issue an RdEn pulse with Address equal to the byte, then go to IDLE.
  - ALU_OPA: issue a WrEn pulse with Address=0 and WrData=opA, then go to ALU_OPB.
  - ALU_OPB: issue a WrEn pulse with Address=1 and WrData=opB, then go to ALU_FUNC.
  - ALU_FUNC: latch ALU_FUN from the byte and issue an ALU_EN pulse, then go to IDLE.
- Address and function fields are truncated: only the low ADDR_WIDTH or FUN_WIDTH bits are used; the upper bits are ignored.
- Illegal state encodings return to IDLE on the next clock.
- Outputs after reset:
  - WrEn, RdEn, ALU_EN, CLK_GATE_EN and FRAME_ABORT are 0.
  - Address, WrData and ALU_FUN are 0.
  - The state is IDLE.

## Timing
- Strobe latency: for a byte accepted at clock edge N, its strobe (WrEn, RdEn or ALU_EN) is high for exactly the cycle between edges N and N+1.
- Address, WrData and ALU_FUN update at the same edge as their strobe and then hold.
- CLK_GATE_EN:
  - Rises at the edge that accepts 0xCC or 0xDD.
  - Stays high through the ALU_EN cycle.
  - Falls at the edge following the ALU_EN cycle.
- Back-to-back bytes (RX_D_VLD high on consecutive cycles) must be handled with no byte lost.
- A new frame may begin in the same cycle that the previous frame's strobe is high.
- Reset asserted mid-frame: the partial frame is discarded, no strobe is issued, and all outputs are forced to their reset values on that edge.
- Reset and RX_D_VLD in the same cycle: reset wins and the byte is dropped.

## Configuration
- `CTRL_RX_TIMEOUT_EN` defined:
  - A 16-bit idle counter runs in every state except IDLE.
  - The counter clears on each accepted byte.
  - When the count reaches TIMEOUT_CYCLES, the FSM returns to IDLE without issuing any strobe, and FRAME_ABORT pulses for one cycle.
  - If CLK_GATE_EN is high at that point, it is cleared on the same edge.
- `CTRL_RX_TIMEOUT_EN` undefined:
  - No counter is built.
  - FRAME_ABORT is tied to 0.
  - A partial frame waits indefinitely for its next byte.

## Test plan
- Register write: bytes 0xAA, 0x15, 0x3C → exactly one WrEn pulse with Address=4'h5 and WrData=8'h3C; no RdEn or ALU_EN.
- Register read: bytes 0xBB, 0x07 → one RdEn pulse with Address=4'h7 in the cycle after the second byte.
- ALU with operands: bytes 0xCC, 0x12, 0x34, 0x02 → WrEn with Address 0 and data 0x12, then WrEn with Address 1 and data 0x34, then ALU_EN with ALU_FUN=4'h2. CLK_GATE_EN is high from the 0xCC edge until the edge after ALU_EN.
- Robustness: junk byte 0x55 in IDLE, followed by back-to-back frame 0xDD, 0x09 on consecutive cycles → no strobe for the 0x55, then one ALU_EN pulse with ALU_FUN=4'h9.
- Reset and timeout:
  - RST asserted between 0xAA and its data byte → no WrEn, state IDLE; a fresh 0xBB frame then works normally.
  - With the macro defined and TIMEOUT_CYCLES=20: byte 0xCC followed by 20 idle cycles → FRAME_ABORT pulses, CLK_GATE_EN falls, and no WrEn is issued.
